// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory: CPU owns priority by default,
// and a wait counter forces one DMA slot after MAX_WAIT consecutive DMA denials.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fsm_state
);

  // Handshake: a requester holds req (and its we/addr/wdata) stable until it sees
  // gnt=1 in the same cycle; the access is issued at the rising edge closing that cycle.
  typedef enum logic {PRI_CPU = 1'b0, PRI_DMA = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DMA = 2'd2} owner_t;

  state_t           state, state_next;
  owner_t           rd_owner, rd_owner_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= PRI_CPU;
      wait_cnt <= '0;
      rd_owner <= OWN_NONE;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      rd_owner <= rd_owner_next;
    end
  end

  // No access is issued while reset is held, so the memory is never written then.
  always_comb begin
    cpu_gnt       = 1'b0;
    dma_gnt       = 1'b0;
    state_next    = state;
    wait_cnt_next = '0;
    rd_owner_next = OWN_NONE;
    case (state)
      PRI_CPU: begin
        cpu_gnt = RST_N & cpu_req;
        dma_gnt = RST_N & ~cpu_req & dma_req;
        if (dma_req && !dma_gnt) begin
          if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            state_next    = PRI_DMA;
            wait_cnt_next = '0;
          end else begin
            wait_cnt_next = wait_cnt + CNT_W'(1);
          end
        end
      end
      PRI_DMA: begin
        dma_gnt    = RST_N & dma_req;
        cpu_gnt    = RST_N & ~dma_req & cpu_req;
        state_next = PRI_CPU;
      end
      default: state_next = PRI_CPU;
    endcase
    if (cpu_gnt && !cpu_we)      rd_owner_next = OWN_CPU;
    else if (dma_gnt && !dma_we) rd_owner_next = OWN_DMA;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // A read still in flight when reset arrives is dropped rather than returned.
  assign cpu_rvalid = RST_N & (rd_owner == OWN_CPU);
  assign dma_rvalid = RST_N & (rd_owner == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;
  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign fsm_state  = state;

endmodule
